// File: rtl/axi_mem_responder_if.sv
// AXI read/write channels plus the AC snoop channel seen by axi_mem_responder.
// Signal names carry the s_axi_ prefix of the responder's bus.
interface axi_mem_responder_if;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [63:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [63:0] s_axi_rdata;
    logic        s_axi_rlast;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [63:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_acvalid;
    logic        s_axi_acready;
    logic [63:0] s_axi_acaddr;
    logic [3:0]  s_axi_acsnoop;

    modport master (
        output s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_rready,
        output s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
        output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
        output s_axi_bready, s_axi_acready,
        input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rlast,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
        input  s_axi_acvalid, s_axi_acaddr, s_axi_acsnoop
    );

    modport slave (
        input  s_axi_arvalid, s_axi_araddr, s_axi_arlen, s_axi_rready,
        input  s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
        input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
        input  s_axi_bready, s_axi_acready,
        output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rlast,
        output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
        output s_axi_acvalid, s_axi_acaddr, s_axi_acsnoop
    );
endinterface

// File: rtl/axi_mem_responder.sv
// Single-outstanding AXI INCR burst responder over a 64-bit word array.
// Define AXI_RESP_SNOOP_EN to follow each write response with a MakeInvalid snoop.
module axi_mem_responder #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned RD_LATENCY = 2,
    parameter logic [63:0] BASE_ADDR  = 64'h0
) (
    input logic                clk,
    input logic                reset,
    axi_mem_responder_if.slave s_axi
);
    localparam int unsigned AW     = $clog2(MEM_WORDS);
    localparam logic [3:0]  LAT_M1 = 4'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_DATA,
        WR_RESP
`ifdef AXI_RESP_SNOOP_EN
        , SNOOP
`endif
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  beat_q;
    logic [7:0]  len_q;
    logic [63:0] addr_q;
    logic        rvalid_q;
    logic [63:0] rdata_q;
    logic        rlast_q;
    logic        wready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        dec_q;
    logic        slv_q;

    logic [63:0] mem_q [MEM_WORDS];

    // Unsigned offset: addresses below BASE_ADDR wrap huge and fall out of range.
    function automatic logic in_rng(input logic [63:0] a);
        return ((a - BASE_ADDR) >> 3) < 64'(MEM_WORDS);
    endfunction

    function automatic logic [AW-1:0] widx(input logic [63:0] a);
        return AW'((a - BASE_ADDR) >> 3);
    endfunction

    logic [63:0] rd_addr;
    logic [63:0] rd_data_d;
    logic        wr_en;
    logic        last_ok;

    assign rd_addr   = (state_q == RD_BURST) ? addr_q + 64'd8 : addr_q;
    assign rd_data_d = in_rng(rd_addr) ? mem_q[widx(rd_addr)] : 64'h0;
    assign wr_en     = !reset && (state_q == WR_DATA) && s_axi.s_axi_wvalid && in_rng(addr_q);
    assign last_ok   = in_rng(addr_q);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi.s_axi_wstrb[b]) mem_q[widx(addr_q)][8*b +: 8] <= s_axi.s_axi_wdata[8*b +: 8];
            end
        end
    end

`ifdef AXI_RESP_SNOOP_EN
    logic [63:0] start_q;
    logic        acvalid_q;
    logic [63:0] acaddr_q;
    logic [3:0]  acsnoop_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            beat_q   <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= '0;
            dec_q    <= 1'b0;
            slv_q    <= 1'b0;
`ifdef AXI_RESP_SNOOP_EN
            start_q   <= '0;
            acvalid_q <= 1'b0;
            acaddr_q  <= '0;
            acsnoop_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // AW has priority; arready is masked combinationally the same cycle.
                    if (s_axi.s_axi_awvalid) begin
                        addr_q   <= s_axi.s_axi_awaddr;
                        len_q    <= s_axi.s_axi_awlen;
                        beat_q   <= '0;
                        dec_q    <= 1'b0;
                        slv_q    <= 1'b0;
                        wready_q <= 1'b1;
                        state_q  <= WR_DATA;
`ifdef AXI_RESP_SNOOP_EN
                        start_q  <= s_axi.s_axi_awaddr;
`endif
                    end else if (s_axi.s_axi_arvalid) begin
                        addr_q  <= s_axi.s_axi_araddr;
                        len_q   <= s_axi.s_axi_arlen;
                        beat_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == LAT_M1) begin
                        cnt_q    <= '0;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_data_d;
                        rlast_q  <= (len_q == 8'd0);
                        state_q  <= RD_BURST;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RD_BURST: begin
                    if (s_axi.s_axi_rready) begin
                        if (rlast_q) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            rdata_q  <= '0;
                            beat_q   <= '0;
                            state_q  <= IDLE;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            addr_q  <= addr_q + 64'd8;
                            rdata_q <= rd_data_d;
                            rlast_q <= (beat_q + 8'd1 == len_q);
                        end
                    end
                end
                WR_DATA: begin
                    if (s_axi.s_axi_wvalid) begin
                        if (!last_ok) dec_q <= 1'b1;
                        if (s_axi.s_axi_wlast) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            beat_q   <= '0;
                            bresp_q  <= (dec_q || !last_ok)           ? 2'b11 :
                                        (slv_q || (beat_q != len_q))  ? 2'b10 : 2'b00;
                            state_q  <= WR_RESP;
                        end else begin
                            // Reaching awlen without wlast is already a length error.
                            if (beat_q == len_q) slv_q <= 1'b1;
                            beat_q <= beat_q + 8'd1;
                            addr_q <= addr_q + 64'd8;
                        end
                    end
                end
                WR_RESP: begin
                    if (s_axi.s_axi_bready) begin
                        bvalid_q <= 1'b0;
                        bresp_q  <= '0;
`ifdef AXI_RESP_SNOOP_EN
                        acvalid_q <= 1'b1;
                        acaddr_q  <= {start_q[63:6], 6'b0};
                        acsnoop_q <= 4'hD;
                        state_q   <= SNOOP;
`else
                        state_q  <= IDLE;
`endif
                    end
                end
`ifdef AXI_RESP_SNOOP_EN
                SNOOP: begin
                    if (s_axi.s_axi_acready) begin
                        acvalid_q <= 1'b0;
                        acaddr_q  <= '0;
                        acsnoop_q <= '0;
                        state_q   <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_axi.s_axi_awready = !reset && (state_q == IDLE);
    assign s_axi.s_axi_arready = !reset && (state_q == IDLE) && !s_axi.s_axi_awvalid;
    assign s_axi.s_axi_rvalid  = rvalid_q;
    assign s_axi.s_axi_rdata   = rdata_q;
    assign s_axi.s_axi_rlast   = rlast_q;
    assign s_axi.s_axi_wready  = wready_q;
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bresp   = bresp_q;

`ifdef AXI_RESP_SNOOP_EN
    assign s_axi.s_axi_acvalid = acvalid_q;
    assign s_axi.s_axi_acaddr  = acaddr_q;
    assign s_axi.s_axi_acsnoop = acsnoop_q;
`else
    logic unused_acready;
    assign unused_acready      = s_axi.s_axi_acready;
    assign s_axi.s_axi_acvalid = 1'b0;
    assign s_axi.s_axi_acaddr  = '0;
    assign s_axi.s_axi_acsnoop = '0;
`endif
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed plus randomized bench for axi_mem_responder against a word-array model.
// All drives and samples happen in the low clock phase, away from the rising edge.
module tb_axi_mem_responder;
    localparam int          MEM_WORDS  = 1024;
    localparam int          RD_LATENCY = 2;
    localparam logic [63:0] BASE       = 64'h0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axi_mem_responder_if axi();

    axi_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .RD_LATENCY(RD_LATENCY),
        .BASE_ADDR (BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .s_axi(axi)
    );

    int tests = 0;
    int fails = 0;

    logic [63:0] mdl [int];
    logic [63:0] wd [0:31];
    logic [7:0]  ws [0:31];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit word_ok(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(MEM_WORDS) * 64'd8);
    endfunction

    function automatic int word_of(input logic [63:0] a);
        return int'((a - BASE) / 64'd8);
    endfunction

    function automatic logic [63:0] exp_rd(input logic [63:0] a);
        if (!word_ok(a)) return 64'h0;
        return mdl[word_of(a)];
    endfunction

    // Entered and left in the low clock phase; arvalid is left untouched unless with_ar.
    task automatic do_write(input logic [63:0] addr, input int len, input int last_at,
                            input bit with_ar, input logic [63:0] ar_addr);
        int          n;
        bit          dec;
        logic [1:0]  eresp;
        logic [63:0] a, cur;
        axi.s_axi_awvalid = 1'b1;
        axi.s_axi_awaddr  = addr;
        axi.s_axi_awlen   = 8'(len);
        if (with_ar) begin
            axi.s_axi_arvalid = 1'b1;
            axi.s_axi_araddr  = ar_addr;
            axi.s_axi_arlen   = 8'd0;
        end
        #1;
        n = 0;
        while (!axi.s_axi_awready && n < 20) begin @(negedge clk); #1; n++; end
        chk("aw_accept", axi.s_axi_awready, 1);
        if (with_ar) chk("ar_blocked_by_aw", axi.s_axi_arready, 0);
        @(posedge clk);
        @(negedge clk);
        axi.s_axi_awvalid = 1'b0;
        dec = 0;
        for (int b = 0; b <= last_at; b++) begin
            axi.s_axi_wvalid = 1'b1;
            axi.s_axi_wdata  = wd[b];
            axi.s_axi_wstrb  = ws[b];
            axi.s_axi_wlast  = (b == last_at);
            #1;
            n = 0;
            while (!axi.s_axi_wready && n < 20) begin @(negedge clk); #1; n++; end
            chk("wready", axi.s_axi_wready, 1);
            @(posedge clk);
            a = addr + 64'(8 * b);
            if (word_ok(a)) begin
                cur = mdl[word_of(a)];
                for (int i = 0; i < 8; i++) if (ws[b][i]) cur[8*i +: 8] = wd[b][8*i +: 8];
                mdl[word_of(a)] = cur;
            end else begin
                dec = 1;
            end
            @(negedge clk);
        end
        axi.s_axi_wvalid = 1'b0;
        axi.s_axi_wlast  = 1'b0;
        eresp = dec ? 2'b11 : (last_at != len) ? 2'b10 : 2'b00;
        #1;
        n = 0;
        while (!axi.s_axi_bvalid && n < 20) begin @(negedge clk); #1; n++; end
        chk("bvalid", axi.s_axi_bvalid, 1);
        chk("bresp", axi.s_axi_bresp, eresp);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk); #1;
            chk("bresp_hold", {axi.s_axi_bvalid, axi.s_axi_bresp}, {1'b1, eresp});
        end
        axi.s_axi_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        axi.s_axi_bready = 1'b0;
        #1;
        chk("bvalid_drop", axi.s_axi_bvalid, 0);
`ifdef AXI_RESP_SNOOP_EN
        chk("acvalid", axi.s_axi_acvalid, 1);
        chk("acaddr", axi.s_axi_acaddr, {addr[63:6], 6'b0});
        chk("acsnoop", axi.s_axi_acsnoop, 4'hD);
        repeat (2) begin
            @(negedge clk); #1;
            chk("ac_hold", {axi.s_axi_acvalid, axi.s_axi_acsnoop, axi.s_axi_acaddr},
                {1'b1, 4'hD, addr[63:6], 6'b0});
        end
        axi.s_axi_acready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        axi.s_axi_acready = 1'b0;
        #1;
        chk("acvalid_drop", axi.s_axi_acvalid, 0);
`else
        chk("no_snoop", axi.s_axi_acvalid, 0);
`endif
        chk("idle_awready", axi.s_axi_awready, 1);
    endtask

    task automatic do_read(input logic [63:0] addr, input int len, input int stall_beat);
        int          n, k;
        logic [63:0] held;
        axi.s_axi_arvalid = 1'b1;
        axi.s_axi_araddr  = addr;
        axi.s_axi_arlen   = 8'(len);
        #1;
        n = 0;
        while (!axi.s_axi_arready && n < 20) begin @(negedge clk); #1; n++; end
        chk("ar_accept", axi.s_axi_arready, 1);
        @(posedge clk);
        @(negedge clk);
        axi.s_axi_arvalid = 1'b0;
        #1;
        k = 0;
        while (!axi.s_axi_rvalid && k < 40) begin @(negedge clk); #1; k++; end
        chk("rd_latency", 64'(k), 64'(RD_LATENCY));
        for (int b = 0; b <= len; b++) begin
            chk("rvalid", axi.s_axi_rvalid, 1);
            chk("rdata", axi.s_axi_rdata, exp_rd(addr + 64'(8 * b)));
            chk("rlast", axi.s_axi_rlast, (b == len));
            if (b == stall_beat) begin
                held = axi.s_axi_rdata;
                repeat (3) begin
                    @(negedge clk); #1;
                    chk("stall_rvalid", axi.s_axi_rvalid, 1);
                    chk("stall_rdata", axi.s_axi_rdata, held);
                end
            end
            axi.s_axi_rready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            axi.s_axi_rready = 1'b0;
            #1;
        end
        chk("rvalid_drop", axi.s_axi_rvalid, 0);
    endtask

    initial begin
        int          w0, ln;
        logic [63:0] a;
        axi.s_axi_arvalid = 0; axi.s_axi_araddr = 0; axi.s_axi_arlen = 0;
        axi.s_axi_rready  = 0;
        axi.s_axi_awvalid = 0; axi.s_axi_awaddr = 0; axi.s_axi_awlen = 0;
        axi.s_axi_wvalid  = 0; axi.s_axi_wdata  = 0; axi.s_axi_wstrb = 0; axi.s_axi_wlast = 0;
        axi.s_axi_bready  = 0; axi.s_axi_acready = 0;

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_arready", axi.s_axi_arready, 0);
        chk("rst_awready", axi.s_axi_awready, 0);
        chk("rst_valids", {axi.s_axi_rvalid, axi.s_axi_wready, axi.s_axi_bvalid, axi.s_axi_acvalid}, 0);
        chk("rst_rdata", axi.s_axi_rdata, 0);
        chk("rst_bresp", axi.s_axi_bresp, 0);
        chk("rst_acaddr", axi.s_axi_acaddr, 0);
        chk("rst_acsnoop", axi.s_axi_acsnoop, 0);
        reset = 1'b0;
        #1;
        chk("idle_arready", axi.s_axi_arready, 1);

        // Preload every word the later reads touch so the model always knows them.
        for (int blk = 0; blk < 4; blk++) begin
            for (int b = 0; b < 16; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
            do_write(64'(blk * 128), 15, 15, 0, 0);
        end
        for (int b = 0; b < 4; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
        do_write(64'h1FE0, 3, 3, 0, 0);

        wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
        ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(64'h40, 1, 1, 0, 0);
        do_read(64'h40, 1, -1);

        do_read(64'h0, 7, 3);

        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        do_write(64'h100, 0, 0, 0, 0);
        wd[0] = 64'hAAAA_AAAA_BBBB_BBBB; ws[0] = 8'h0F;
        do_write(64'h100, 0, 0, 0, 0);
        do_read(64'h100, 0, -1);

        wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
        do_write(64'h180, 0, 0, 1, 64'h180);
        do_read(64'h180, 0, -1);

        // 0x2000 is the first byte past a 1024-word array.
        wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
        do_write(64'h2000, 0, 0, 0, 0);
        wd[0] = {$urandom, $urandom}; wd[1] = {$urandom, $urandom};
        ws[0] = 8'hFF; ws[1] = 8'hFF;
        do_write(64'h1FF8, 1, 1, 0, 0);
        do_read(64'h1FF0, 3, -1);

        for (int b = 0; b < 3; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
        do_write(64'h80, 3, 1, 0, 0);
        do_write(64'h90, 0, 2, 0, 0);
        do_read(64'h80, 4, -1);

        wd[0] = {$urandom, $urandom}; ws[0] = 8'h3C;
        do_write(64'h4D, 0, 0, 0, 0);
        do_read(64'h48, 0, -1);

        // Reset in the middle of a read burst: no further beats, back to idle.
        axi.s_axi_arvalid = 1'b1; axi.s_axi_araddr = 64'h0; axi.s_axi_arlen = 8'd7;
        #1;
        chk("abort_ar_accept", axi.s_axi_arready, 1);
        @(posedge clk);
        @(negedge clk);
        axi.s_axi_arvalid = 1'b0;
        #1;
        repeat (RD_LATENCY) begin @(negedge clk); #1; end
        chk("abort_rvalid_up", axi.s_axi_rvalid, 1);
        reset = 1'b1;
        #1;
        chk("abort_rst_ready", {axi.s_axi_arready, axi.s_axi_awready}, 0);
        @(posedge clk);
        @(negedge clk); #1;
        chk("abort_rvalid", axi.s_axi_rvalid, 0);
        chk("abort_rdata", axi.s_axi_rdata, 0);
        chk("abort_rlast", axi.s_axi_rlast, 0);
        reset = 1'b0;
        #1;
        chk("abort_idle", axi.s_axi_arready, 1);
        do_read(64'h40, 1, 0);

        for (int it = 0; it < 12; it++) begin
            w0 = $urandom_range(0, 55);
            ln = $urandom_range(0, 7);
            a  = 64'(w0) * 64'd8 + 64'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b <= ln; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'($urandom); end
                do_write(a, ln, ln, 0, 0);
            end else begin
                do_read(a, ln, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, ln)) : -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
